// File: rtl/mpadder_arbiter_if.sv
// mpadder_arbiter_if: two requester ports plus the shared adder port.
// Ports: reqN_valid/sub/a/b in, reqN_done/err/result out,
//        add_start/subtract/a/b out, add_result/done in, busy out.
// slave = arbiter side, master = requesters and adder side.
interface mpadder_arbiter_if #(
  parameter int W = 1027
);
  logic         req0_valid;
  logic         req0_sub;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_done;
  logic         req0_err;
  logic [W:0]   req0_result;
  logic         req1_valid;
  logic         req1_sub;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_done;
  logic         req1_err;
  logic [W:0]   req1_result;
  logic         add_start;
  logic         add_subtract;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W:0]   add_result;
  logic         add_done;
  logic         busy;

  modport slave (
    input  req0_valid, req0_sub, req0_a, req0_b,
    input  req1_valid, req1_sub, req1_a, req1_b,
    input  add_result, add_done,
    output req0_done, req0_err, req0_result,
    output req1_done, req1_err, req1_result,
    output add_start, add_subtract, add_a, add_b,
    output busy
  );

  modport master (
    output req0_valid, req0_sub, req0_a, req0_b,
    output req1_valid, req1_sub, req1_a, req1_b,
    output add_result, add_done,
    input  req0_done, req0_err, req0_result,
    input  req1_done, req1_err, req1_result,
    input  add_start, add_subtract, add_a, add_b,
    input  busy
  );
endinterface

// File: rtl/mpadder_arbiter.sv
// mpadder_arbiter: round-robin share of one multi-precision adder.
// Ports: clk, reset (async, active-high), bus (mpadder_arbiter_if.slave).
module mpadder_arbiter #(
  parameter int W       = 1027,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  mpadder_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic         grant_q, grant_d;
  logic         last_q, last_d;
  logic         err_q, err_d;
  logic         sub_q, sub_d;
  logic [7:0]   wd_q, wd_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W:0]   res0_q, res0_d;
  logic [W:0]   res1_q, res1_d;
  logic         v0, v1, resp;

  assign v0   = bus.req0_valid;
  assign v1   = bus.req1_valid;
  assign resp = (state_q == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      sub_q   <= 1'b0;
      wd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
      sub_q   <= sub_d;
      wd_q    <= wd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q;
    sub_d   = sub_q;
    wd_d    = wd_q;
    a_d     = a_q;
    b_d     = b_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    unique case (state_q)
      IDLE: begin
        if (v0 || v1) begin
          // On a tie the requester not served last time wins.
          grant_d = (v0 && v1) ? ~last_q : v1;
          sub_d   = grant_d ? bus.req1_sub : bus.req0_sub;
          a_d     = grant_d ? bus.req1_a : bus.req0_a;
          b_d     = grant_d ? bus.req1_b : bus.req0_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A done seen here belongs to nothing we issued.
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.add_done) begin
          if (grant_q) res1_d = bus.add_result;
          else         res0_d = bus.add_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.add_start    = (state_q == ISSUE);
  assign bus.add_subtract = sub_q;
  assign bus.add_a        = a_q;
  assign bus.add_b        = b_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.req0_done    = resp & ~grant_q;
  assign bus.req0_err     = resp & ~grant_q & err_q;
  assign bus.req0_result  = res0_q;
  assign bus.req1_done    = resp & grant_q;
  assign bus.req1_err     = resp & grant_q & err_q;
  assign bus.req1_result  = res1_q;
endmodule

// File: tb/tb_mpadder_arbiter.sv
// tb_mpadder_arbiter: scoreboard bench for the shared-adder arbiter.
// Adder model with programmable latency, hang and stale-done modes.
module tb_mpadder_arbiter;
  localparam int W  = 1027;
  localparam int TO = 16;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           chk;
  } op_t;

  typedef struct {
    int       id;
    logic [W:0] res;
    logic     err;
  } obs_t;

  typedef struct {
    logic [W:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mpadder_arbiter_if #(.W(W)) bus ();

  mpadder_arbiter #(
    .W(W),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t exp0[$];
  exp_t exp1[$];
  obs_t obs[$];
  logic [W:0] last_res[2];

  int starts = 0;
  int hold_viol = 0;
  int quiet_viol = 0;
  bit hang = 0;
  bit stale = 0;
  bit abort = 0;
  int lat = 2;

  // Adder model: done pulses lat cycles after the start edge.
  int cnt = 0;
  logic done_r = 1'b0;
  logic [W:0] res_r = '0;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (bus.add_start && !hang) begin
      cnt <= lat;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        done_r <= 1'b1;
        res_r <= bus.add_subtract ?
          ({1'b0, bus.add_a} - {1'b0, bus.add_b}) :
          ({1'b0, bus.add_a} + {1'b0, bus.add_b});
      end
    end
  end

  assign bus.add_done = done_r | (stale & bus.add_start);
  assign bus.add_result = (stale && bus.add_start) ?
    {(W+1){1'b1}} : res_r;

  function automatic op_t mk(logic s, logic [W-1:0] a,
                             logic [W-1:0] b);
    op_t o;
    o.sub = s;
    o.a = a;
    o.b = b;
    o.chk = 1'b1;
    return o;
  endfunction

  task automatic apply(int id, op_t o);
    logic [W:0] r;
    exp_t e;
    r = o.sub ? ({1'b0, o.a} - {1'b0, o.b}) :
                ({1'b0, o.a} + {1'b0, o.b});
    if (hang) begin
      e.res = last_res[id];
      e.err = 1'b1;
    end else begin
      e.res = r;
      e.err = 1'b0;
      if (o.chk) last_res[id] = r;
    end
    if (id == 0) begin
      bus.req0_sub = o.sub;
      bus.req0_a = o.a;
      bus.req0_b = o.b;
      bus.req0_valid = 1'b1;
      if (o.chk) exp0.push_back(e);
    end else begin
      bus.req1_sub = o.sub;
      bus.req1_a = o.a;
      bus.req1_b = o.b;
      bus.req1_valid = 1'b1;
      if (o.chk) exp1.push_back(e);
    end
  endtask

  // Monitor + requester driver, all on the falling edge.
  logic prev_busy = 1'b0;
  logic prev_sub = 1'b0;
  logic [W-1:0] prev_a = '0;
  logic [W-1:0] prev_b = '0;
  logic [W:0] prev_r0 = '0;
  logic [W:0] prev_r1 = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.add_start) starts++;
      if (bus.req0_done)
        obs.push_back('{0, bus.req0_result, bus.req0_err});
      if (bus.req1_done)
        obs.push_back('{1, bus.req1_result, bus.req1_err});
      if (bus.busy && prev_busy &&
          (bus.add_a !== prev_a || bus.add_b !== prev_b ||
           bus.add_subtract !== prev_sub))
        hold_viol++;
      if (!bus.req0_done && bus.req0_result !== prev_r0)
        quiet_viol++;
      if (!bus.req1_done && bus.req1_result !== prev_r1)
        quiet_viol++;
    end
    if (abort) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      pend0.delete();
      pend1.delete();
    end else begin
      if (bus.req0_done || !bus.req0_valid) begin
        if (pend0.size() > 0) apply(0, pend0.pop_front());
        else if (bus.req0_done) bus.req0_valid = 1'b0;
      end
      if (bus.req1_done || !bus.req1_valid) begin
        if (pend1.size() > 0) apply(1, pend1.pop_front());
        else if (bus.req1_done) bus.req1_valid = 1'b0;
      end
    end
    prev_busy = bus.busy;
    prev_sub = bus.add_subtract;
    prev_a = bus.add_a;
    prev_b = bus.add_b;
    prev_r0 = bus.req0_result;
    prev_r1 = bus.req1_result;
  end

  task automatic wait_obs(input int n, output bit ok);
    int k = 0;
    while (obs.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    ok = (obs.size() >= n);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.add_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl: busy=%b start=%b, want 0 0",
               bus.busy, bus.add_start);
    end
    checks++;
    if (bus.add_a !== '0 || bus.add_b !== '0 ||
        bus.add_subtract !== 1'b0) begin
      errors++;
      $display("FAIL rst_ops: a=%h b=%h sub=%b, want 0",
               bus.add_a[31:0], bus.add_b[31:0], bus.add_subtract);
    end
    checks++;
    if (bus.req0_done !== 1'b0 || bus.req0_err !== 1'b0 ||
        bus.req0_result !== '0) begin
      errors++;
      $display("FAIL rst_req0: done=%b err=%b res=%h, want 0",
               bus.req0_done, bus.req0_err, bus.req0_result[31:0]);
    end
    checks++;
    if (bus.req1_done !== 1'b0 || bus.req1_err !== 1'b0 ||
        bus.req1_result !== '0) begin
      errors++;
      $display("FAIL rst_req1: done=%b err=%b res=%h, want 0",
               bus.req1_done, bus.req1_err, bus.req1_result[31:0]);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, want 0", bus.busy);
    end
  endtask

  task automatic test_tie;
    logic [W-1:0] big;
    logic [W:0] want1;
    obs_t o;
    exp_t e;
    bit ok;
    int s0 = starts;
    big = '0;
    big[W-1] = 1'b1;
    want1 = 'd6;
    @(posedge clk);
    #1;
    pend0.push_back(mk(1'b0, big, W'(1)));
    pend1.push_back(mk(1'b1, W'(10), W'(4)));
    wait_obs(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tie_timeout: got %0d dones, want 2", obs.size());
    end
    for (int i = 0; i < 2 && obs.size() > 0; i++) begin
      o = obs.pop_front();
      checks++;
      if (o.id !== i) begin
        errors++;
        $display("FAIL tie_order[%0d]: got req%0d, want req%0d",
                 i, o.id, i);
      end
      if (o.id == 0 && exp0.size() > 0) e = exp0.pop_front();
      else if (o.id == 1 && exp1.size() > 0) e = exp1.pop_front();
      else begin e.res = 'x; e.err = 1'bx; end
      checks++;
      if (o.res !== e.res || o.err !== e.err) begin
        errors++;
        $display("FAIL tie_res req%0d: got %b_%h err=%b, want %b_%h err=%b",
                 o.id, o.res[W], o.res[63:0], o.err,
                 e.res[W], e.res[63:0], e.err);
      end
    end
    checks++;
    if (bus.req1_result !== want1) begin
      errors++;
      $display("FAIL tie_sub: got %h, want 6", bus.req1_result[31:0]);
    end
    checks++;
    if (starts - s0 != 2 || hold_viol != 0) begin
      errors++;
      $display("FAIL tie_hold: starts=%0d viol=%0d, want 2 0",
               starts - s0, hold_viol);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    exp_t e;
    bit ok;
    int s0 = starts;
    @(posedge clk);
    #1;
    pend0.push_back(mk(1'b0, W'(100), W'(23)));
    pend1.push_back(mk(1'b1, W'(7), W'(9)));
    pend0.push_back(mk(1'b1, W'(1000), W'(1)));
    pend1.push_back(mk(1'b0, {W{1'b1}}, W'(1)));
    wait_obs(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d dones, want 4", obs.size());
    end
    for (int i = 0; i < 4 && obs.size() > 0; i++) begin
      o = obs.pop_front();
      checks++;
      if (o.id !== (i % 2)) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got req%0d, want req%0d",
                 i, o.id, i % 2);
      end
      if (o.id == 0 && exp0.size() > 0) e = exp0.pop_front();
      else if (o.id == 1 && exp1.size() > 0) e = exp1.pop_front();
      else begin e.res = 'x; e.err = 1'bx; end
      checks++;
      if (o.res !== e.res || o.err !== e.err) begin
        errors++;
        $display("FAIL b2b_res req%0d: got %b_%h err=%b, want %b_%h err=%b",
                 o.id, o.res[W], o.res[63:0], o.err,
                 e.res[W], e.res[63:0], e.err);
      end
    end
    repeat (4) @(posedge clk);
    checks++;
    if (starts - s0 != 4 || obs.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: starts=%0d extra=%0d, want 4 0",
               starts - s0, obs.size());
    end
    checks++;
    if (hold_viol != 0 || quiet_viol != 0) begin
      errors++;
      $display("FAIL b2b_stable: hold=%0d quiet=%0d, want 0 0",
               hold_viol, quiet_viol);
    end
  endtask

  task automatic test_single;
    obs_t o;
    exp_t e;
    int n = 0;
    int s0 = starts;
    @(posedge clk);
    #1;
    pend0.push_back(mk(1'b0, W'(5), W'(3)));
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.req0_done && n < 40);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL single_lat: got %0d cycles, want 5", n);
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL single_cnt: got %0d dones, want 1", obs.size());
    end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.id == 0 && exp0.size() > 0) e = exp0.pop_front();
      else begin e.res = 'x; e.err = 1'bx; end
      checks++;
      if (o.id !== 0 || o.res !== e.res || o.err !== e.err) begin
        errors++;
        $display("FAIL single_res: got req%0d %h err=%b, want req0 %h err=%b",
                 o.id, o.res[31:0], o.err, e.res[31:0], e.err);
      end
    end
    checks++;
    if (starts - s0 != 1) begin
      errors++;
      $display("FAIL single_start: got %0d, want 1", starts - s0);
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    exp_t e;
    bit ok;
    int n = 0;
    hang = 1'b1;
    @(posedge clk);
    #1;
    pend1.push_back(mk(1'b0, W'(77), W'(11)));
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.req1_done && n < 60);
    checks++;
    if (n != TO + 2 || bus.req1_err !== 1'b1) begin
      errors++;
      $display("FAIL to_lat: got %0d cycles err=%b, want %0d err=1",
               n, bus.req1_err, TO + 2);
    end
    @(negedge clk);
    #1;
    hang = 1'b0;
    pend1.push_back(mk(1'b1, W'(50), W'(8)));
    wait_obs(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_wait: got %0d dones, want 2", obs.size());
    end
    for (int i = 0; i < 2 && obs.size() > 0; i++) begin
      o = obs.pop_front();
      if (o.id == 1 && exp1.size() > 0) e = exp1.pop_front();
      else begin e.res = 'x; e.err = 1'bx; end
      checks++;
      if (o.id !== 1 || o.res !== e.res || o.err !== e.err) begin
        errors++;
        $display("FAIL to_res[%0d]: got req%0d %h err=%b, want req1 %h err=%b",
                 i, o.id, o.res[31:0], o.err, e.res[31:0], e.err);
      end
    end
  endtask

  task automatic test_reset_mid;
    op_t op;
    lat = 6;
    op = mk(1'b0, W'(9), W'(9));
    op.chk = 1'b0;
    @(posedge clk);
    #1;
    pend0.push_back(op);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    abort = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.add_start !== 1'b0 ||
        bus.add_a !== '0) begin
      errors++;
      $display("FAIL rmid_ctl: busy=%b start=%b a=%h, want 0",
               bus.busy, bus.add_start, bus.add_a[31:0]);
    end
    checks++;
    if (bus.req0_result !== '0 || bus.req1_result !== '0 ||
        bus.req0_done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_req: r0=%h r1=%h done=%b, want 0",
               bus.req0_result[31:0], bus.req1_result[31:0],
               bus.req0_done);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_res[0] = '0;
    last_res[1] = '0;
    repeat (12) @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (obs.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_late: dones=%0d busy=%b, want 0 0",
               obs.size(), bus.busy);
    end
    obs.delete();
    lat = 2;
  endtask

  task automatic test_stale;
    obs_t o;
    exp_t e;
    int n = 0;
    stale = 1'b1;
    @(posedge clk);
    #1;
    pend0.push_back(mk(1'b1, W'(100), W'(7)));
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.req0_done && n < 40);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL stale_lat: got %0d cycles, want 5", n);
    end
    stale = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL stale_cnt: got %0d dones, want 1", obs.size());
    end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.id == 0 && exp0.size() > 0) e = exp0.pop_front();
      else begin e.res = 'x; e.err = 1'bx; end
      checks++;
      if (o.id !== 0 || o.res !== e.res || o.err !== e.err) begin
        errors++;
        $display("FAIL stale_res: got req%0d %b_%h err=%b, want req0 %b_%h err=%b",
                 o.id, o.res[W], o.res[31:0], o.err,
                 e.res[W], e.res[31:0], e.err);
      end
    end
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_sub = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_valid = 1'b0;
    bus.req1_sub = 1'b0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    last_res[0] = '0;
    last_res[1] = '0;
    test_reset();
    test_tie();
    test_back_to_back();
    test_single();
    test_timeout();
    test_reset_mid();
    test_stale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1);
  end
endmodule
